lsu_axi_master: RTL and testbench

- Converts single LSU load/store requests into AXI4 read or write transactions.
- Drives the data-side port of the AXI arbiter (addr_r/r/addr_w/w/bkwd channels) and returns an aligned, sign/zero-extended result to the LSU stage.
- One outstanding transaction; single beat (len 0, FIXED burst applied by arbiter); 32-bit bus.

---
 rtl/lsu_axi_master_pkg.sv | 58 +++++
 rtl/lsu_axi_master_if.sv | 57 +++++
 rtl/lsu_axi_align.sv | 59 +++++
 rtl/lsu_axi_master.sv | 187 ++++++++++++++++++
 tb/tb_lsu_axi_master.sv | 354 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_axi_master_pkg.sv
// lsu_axi_master_pkg
// Shared definitions for the LSU-to-AXI data-side master:
//   - LSU access size encodings (BYTE/HALF/WORD)
//   - AXI response code OKAY, AXI AxSIZE encodings and the fixed AXI ID
//   - FSM state encoding (exposed on the top-level debug port)
//   - small helpers for alignment checking and AxSIZE generation
package lsu_axi_master_pkg;

  // LSU access sizes as carried on req_size
  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  // AXI response codes
  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  // AXI AxSIZE encodings (bytes per beat = 2**AxSIZE)
  localparam logic [2:0] AXI_ADDR_SIZE_1 = 3'd0;
  localparam logic [2:0] AXI_ADDR_SIZE_2 = 3'd1;
  localparam logic [2:0] AXI_ADDR_SIZE_4 = 3'd2;

  // Transaction ID used by this master on the arbiter's data-side port
  localparam logic [3:0] AXI_ID = 4'd0;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_ADDR = 3'd1,
    ST_RD_DATA = 3'd2,
    ST_WR      = 3'd3,
    ST_WR_RESP = 3'd4,
    ST_RSP     = 3'd5
  } lsu_state_e;

  // Half needs addr[0]==0, word needs addr[1:0]==0; size 3 is never legal.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
    logic mis;
    case (size)
      SIZE_BYTE: mis = 1'b0;
      SIZE_HALF: mis = offset[0];
      SIZE_WORD: mis = (offset != 2'b00);
      default:   mis = 1'b1;
    endcase
    return mis;
  endfunction

  // AxSIZE is the LSU size zero-extended to three bits.
  function automatic logic [2:0] axi_size(input logic [1:0] size);
    logic [2:0] sz;
    case (size)
      SIZE_BYTE: sz = AXI_ADDR_SIZE_1;
      SIZE_HALF: sz = AXI_ADDR_SIZE_2;
      SIZE_WORD: sz = AXI_ADDR_SIZE_4;
      default:   sz = {1'b0, size};
    endcase
    return sz;
  endfunction

endpackage

// File: rtl/lsu_axi_master_if.sv
// lsu_axi_master_if
// Data-side AXI4 channels between lsu_axi_master and the AXI arbiter.
// Single beat only: burst length/type are supplied by the arbiter.
//   ar_*  read address   (master -> slave, ar_ready back)
//   r_*   read data      (slave -> master, r_ready back)
//   aw_*  write address  (master -> slave, aw_ready back)
//   w_*   write data     (master -> slave, w_ready back)
//   b_*   write response (slave -> master, b_ready back)
//
// Handshake rule for every channel: a transfer happens on a rising clock
// edge where both valid and ready are high. Once valid is raised it stays
// high, with its payload unchanged, until that transfer happens; ready may
// be raised or lowered at any time and never depends on valid falling.
interface lsu_axi_master_if #(
  parameter int ADDR_LEN = 32,
  parameter int DATA_LEN = 32
);
  logic [ADDR_LEN-1:0]   ar_addr;
  logic                  ar_valid;
  logic [2:0]            ar_size;
  logic                  ar_ready;

  logic [DATA_LEN-1:0]   r_data;
  logic [1:0]            r_resp;
  logic                  r_valid;
  logic                  r_ready;

  logic [ADDR_LEN-1:0]   aw_addr;
  logic                  aw_valid;
  logic [2:0]            aw_size;
  logic                  aw_ready;

  logic [DATA_LEN-1:0]   w_data;
  logic [DATA_LEN/8-1:0] w_strb;
  logic                  w_valid;
  logic                  w_ready;

  logic [1:0]            b_resp;
  logic                  b_valid;
  logic                  b_ready;

  modport master (
    output ar_addr, ar_valid, ar_size, input  ar_ready,
    input  r_data, r_resp, r_valid,    output r_ready,
    output aw_addr, aw_valid, aw_size, input  aw_ready,
    output w_data, w_strb, w_valid,    input  w_ready,
    input  b_resp, b_valid,            output b_ready
  );

  modport slave (
    input  ar_addr, ar_valid, ar_size, output ar_ready,
    output r_data, r_resp, r_valid,    input  r_ready,
    input  aw_addr, aw_valid, aw_size, output aw_ready,
    input  w_data, w_strb, w_valid,    output w_ready,
    output b_resp, b_valid,            input  b_ready
  );
endinterface

// File: rtl/lsu_axi_align.sv
// lsu_axi_align
// Combinational lane steering for a 32-bit AXI data bus.
//   Write side: wr_data_in (right-aligned) shifted to its byte lane by
//               wr_offset, plus the matching byte strobe.
//   Read side:  rd_data_in shifted down by rd_offset, then byte/half
//               sign- or zero-extended (rd_unsigned); words pass through.
// Ports:
//   wr_offset, wr_size, wr_data_in  -> wr_data_out, wr_strb
//   rd_offset, rd_size, rd_unsigned, rd_data_in -> rd_data_out
module lsu_axi_align
  import lsu_axi_master_pkg::*;
#(
  parameter int DATA_LEN = 32
) (
  input  logic [1:0]            wr_offset,
  input  logic [1:0]            wr_size,
  input  logic [DATA_LEN-1:0]   wr_data_in,
  output logic [DATA_LEN-1:0]   wr_data_out,
  output logic [DATA_LEN/8-1:0] wr_strb,
  input  logic [1:0]            rd_offset,
  input  logic [1:0]            rd_size,
  input  logic                  rd_unsigned,
  input  logic [DATA_LEN-1:0]   rd_data_in,
  output logic [DATA_LEN-1:0]   rd_data_out
);

  logic [DATA_LEN/8-1:0] strb_base;
  logic [DATA_LEN-1:0]   rd_shifted;
  logic                  sign_bit;

  always_comb begin
    strb_base = '0;
    case (wr_size)
      SIZE_BYTE: strb_base[0]   = 1'b1;
      SIZE_HALF: strb_base[1:0] = 2'b11;
      default:   strb_base      = '1;
    endcase
    wr_data_out = wr_data_in << {wr_offset, 3'b000};
    wr_strb     = strb_base << wr_offset;
  end

  always_comb begin
    rd_shifted  = rd_data_in >> {rd_offset, 3'b000};
    sign_bit    = 1'b0;
    rd_data_out = rd_shifted;
    case (rd_size)
      SIZE_BYTE: begin
        sign_bit    = rd_shifted[7] & ~rd_unsigned;
        rd_data_out = {{(DATA_LEN-8){sign_bit}}, rd_shifted[7:0]};
      end
      SIZE_HALF: begin
        sign_bit    = rd_shifted[15] & ~rd_unsigned;
        rd_data_out = {{(DATA_LEN-16){sign_bit}}, rd_shifted[15:0]};
      end
      default: rd_data_out = rd_shifted;
    endcase
  end

endmodule

// File: rtl/lsu_axi_master.sv
// lsu_axi_master
// Turns one LSU load/store request at a time into a single-beat AXI4 read
// or write on the arbiter's data-side port and returns an aligned,
// extended result to the LSU stage.
// Ports:
//   clock, reset       clock; synchronous active-high reset
//   req_*              LSU request (accepted on req_valid & req_ready)
//   rsp_*              one-cycle result pulse, load data, error flag
//   axi                lsu_axi_master_if.master (ar/r/aw/w/b channels)
//   state_dbg          current FSM state
//   perf_*_cnt         load/store/stall counters, present only when
//                      LSU_AXI_PERF_EN is defined
module lsu_axi_master
  import lsu_axi_master_pkg::*;
#(
  parameter int ADDR_LEN = 32,
  parameter int DATA_LEN = 32
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_LEN-1:0] req_addr,
  input  logic [1:0]          req_size,
  input  logic                req_unsigned,
  input  logic [DATA_LEN-1:0] req_wdata,
  output logic                rsp_valid,
  output logic [DATA_LEN-1:0] rsp_rdata,
  output logic                rsp_err,
  lsu_axi_master_if.master    axi,
  output lsu_state_e          state_dbg
`ifdef LSU_AXI_PERF_EN
  ,
  output logic [31:0]         perf_load_cnt,
  output logic [31:0]         perf_store_cnt,
  output logic [31:0]         perf_stall_cnt
`endif
);

  lsu_state_e            state_q, state_d;
  logic                  we_q;
  logic [ADDR_LEN-1:0]   addr_q;
  logic [1:0]            size_q;
  logic                  unsigned_q;
  logic [DATA_LEN-1:0]   wdata_q;
  logic [DATA_LEN/8-1:0] wstrb_q;
  logic                  aw_done_q, w_done_q;
  logic [DATA_LEN-1:0]   rdata_q;
  logic                  err_q;

  logic                  accept;
  logic                  misaligned;
  logic                  aw_valid_int, w_valid_int;
  logic                  aw_hs, w_hs;
  logic [DATA_LEN-1:0]   wr_aligned;
  logic [DATA_LEN/8-1:0] wr_strb;
  logic [DATA_LEN-1:0]   rd_extended;

  assign accept     = req_valid & req_ready;
  assign misaligned = is_misaligned(req_size, req_addr[1:0]);

  // Write lanes are computed from the live request and registered at accept;
  // read lanes use the latched offset/size against the returning r_data.
  lsu_axi_align #(.DATA_LEN(DATA_LEN)) u_align (
    .wr_offset   (req_addr[1:0]),
    .wr_size     (req_size),
    .wr_data_in  (req_wdata),
    .wr_data_out (wr_aligned),
    .wr_strb     (wr_strb),
    .rd_offset   (addr_q[1:0]),
    .rd_size     (size_q),
    .rd_unsigned (unsigned_q),
    .rd_data_in  (axi.r_data),
    .rd_data_out (rd_extended)
  );

  // AW and W are raised together; each falls on its own handshake so the
  // arbiter may take them in either order.
  assign aw_valid_int = (state_q == ST_WR) & ~aw_done_q;
  assign w_valid_int  = (state_q == ST_WR) & ~w_done_q;
  assign aw_hs        = aw_valid_int & axi.aw_ready;
  assign w_hs         = w_valid_int & axi.w_ready;

  // Outputs decoded from registered state
  assign req_ready    = (state_q == ST_IDLE);
  assign rsp_valid    = (state_q == ST_RSP);
  assign rsp_rdata    = rdata_q;
  assign rsp_err      = err_q;
  assign state_dbg    = state_q;

  assign axi.ar_valid = (state_q == ST_RD_ADDR);
  assign axi.ar_addr  = addr_q;
  assign axi.ar_size  = axi_size(size_q);
  assign axi.r_ready  = (state_q == ST_RD_DATA);
  assign axi.aw_valid = aw_valid_int;
  assign axi.aw_addr  = addr_q;
  assign axi.aw_size  = axi_size(size_q);
  assign axi.w_valid  = w_valid_int;
  assign axi.w_data   = wdata_q;
  assign axi.w_strb   = wstrb_q;
  assign axi.b_ready  = (state_q == ST_WR_RESP);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (misaligned)  state_d = ST_RSP;
          else if (req_we) state_d = ST_WR;
          else             state_d = ST_RD_ADDR;
        end
      end
      ST_RD_ADDR: if (axi.ar_ready) state_d = ST_RD_DATA;
      ST_RD_DATA: if (axi.r_valid)  state_d = ST_RSP;
      ST_WR: begin
        if ((aw_done_q | aw_hs) & (w_done_q | w_hs)) state_d = ST_WR_RESP;
      end
      ST_WR_RESP: if (axi.b_valid)  state_d = ST_RSP;
      ST_RSP:     state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      we_q       <= 1'b0;
      addr_q     <= '0;
      size_q     <= 2'b00;
      unsigned_q <= 1'b0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q       <= req_we;
        addr_q     <= req_addr;
        size_q     <= req_size;
        unsigned_q <= req_unsigned;
        aw_done_q  <= 1'b0;
        w_done_q   <= 1'b0;
        // Stores and misaligned accesses report zero data; a misaligned
        // access is already known to be an error at accept.
        rdata_q    <= '0;
        err_q      <= misaligned;
        if (req_we & ~misaligned) begin
          wdata_q <= wr_aligned;
          wstrb_q <= wr_strb;
        end
      end
      if (aw_hs) aw_done_q <= 1'b1;
      if (w_hs)  w_done_q  <= 1'b1;
      if ((state_q == ST_RD_DATA) & axi.r_valid) begin
        rdata_q <= rd_extended;
        err_q   <= (axi.r_resp != AXI_RESP_OKAY);
      end
      if ((state_q == ST_WR_RESP) & axi.b_valid) begin
        err_q <= (axi.b_resp != AXI_RESP_OKAY);
      end
    end
  end

`ifdef LSU_AXI_PERF_EN
  // Counters wrap naturally at 2^32.
  always_ff @(posedge clock) begin
    if (reset) begin
      perf_load_cnt  <= '0;
      perf_store_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (state_q == ST_RSP) begin
        if (we_q) perf_store_cnt <= perf_store_cnt + 32'd1;
        else      perf_load_cnt  <= perf_load_cnt + 32'd1;
      end
      if ((state_q != ST_IDLE) && (state_q != ST_RSP)) begin
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_lsu_axi_master.sv
// tb_lsu_axi_master
// Directed bench for lsu_axi_master: an AXI slave responder with
// per-channel wait-cycle settings, a request driver task, an expected-data
// queue for load results and one summary line at the end.
module tb_lsu_axi_master;
  import lsu_axi_master_pkg::*;

  // ---------------- clock / reset ----------------
  logic clock;
  logic reset;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // ---------------- DUT ----------------
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  lsu_state_e  state_dbg;
`ifdef LSU_AXI_PERF_EN
  logic [31:0] perf_load_cnt, perf_store_cnt, perf_stall_cnt;
`endif

  lsu_axi_master_if #(.ADDR_LEN(32), .DATA_LEN(32)) axi ();

  lsu_axi_master #(.ADDR_LEN(32), .DATA_LEN(32)) dut (
    .clock        (clock),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .axi          (axi),
    .state_dbg    (state_dbg)
`ifdef LSU_AXI_PERF_EN
    ,
    .perf_load_cnt  (perf_load_cnt),
    .perf_store_cnt (perf_store_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  // ---------------- slave responder ----------------
  int          ar_delay = 0, r_delay = 0, aw_delay = 0, w_delay = 0, b_delay = 0;
  logic [31:0] rd_data = 32'h0;
  logic [1:0]  rd_resp = 2'b00;
  logic [1:0]  wr_resp = 2'b00;

  int          ar_valid_cycles = 0, aw_valid_cycles = 0, w_valid_cycles = 0;
  int          w_unstable = 0;
  logic        aw_w_together = 1'b0;
  logic [31:0] seen_ar_addr = 32'h0, seen_aw_addr = 32'h0, seen_w_data = 32'h0;
  logic [2:0]  seen_ar_size = 3'h0, seen_aw_size = 3'h0;
  logic [3:0]  seen_w_strb = 4'h0;

  initial begin
    int ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
    logic        aw_prev, w_prev;
    logic [31:0] w_prev_data;
    ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
    aw_prev = 1'b0; w_prev = 1'b0; w_prev_data = 32'h0;
    axi.ar_ready = 1'b0; axi.r_valid = 1'b0; axi.r_data = 32'h0; axi.r_resp = 2'b00;
    axi.aw_ready = 1'b0; axi.w_ready = 1'b0; axi.b_valid = 1'b0; axi.b_resp = 2'b00;
    forever begin
      @(negedge clock);
      // AR
      if (axi.ar_valid === 1'b1) begin
        ar_valid_cycles++;
        if (ar_cnt >= ar_delay) begin
          axi.ar_ready = 1'b1;
          seen_ar_addr = axi.ar_addr;
          seen_ar_size = axi.ar_size;
        end else begin
          axi.ar_ready = 1'b0;
          ar_cnt++;
        end
      end else begin
        axi.ar_ready = 1'b0;
        ar_cnt = 0;
      end
      // R
      if (axi.r_ready === 1'b1) begin
        if (r_cnt >= r_delay) begin
          axi.r_valid = 1'b1; axi.r_data = rd_data; axi.r_resp = rd_resp;
        end else begin
          axi.r_valid = 1'b0; r_cnt++;
        end
      end else begin
        axi.r_valid = 1'b0; r_cnt = 0;
      end
      // AW
      if ((axi.aw_valid === 1'b1) && !aw_prev) aw_w_together = (axi.w_valid === 1'b1);
      aw_prev = (axi.aw_valid === 1'b1);
      if (axi.aw_valid === 1'b1) begin
        aw_valid_cycles++;
        if (aw_cnt >= aw_delay) begin
          axi.aw_ready = 1'b1;
          seen_aw_addr = axi.aw_addr;
          seen_aw_size = axi.aw_size;
        end else begin
          axi.aw_ready = 1'b0;
          aw_cnt++;
        end
      end else begin
        axi.aw_ready = 1'b0;
        aw_cnt = 0;
      end
      // W
      if (axi.w_valid === 1'b1) begin
        w_valid_cycles++;
        if (w_prev && (axi.w_data !== w_prev_data)) w_unstable++;
        if (w_cnt >= w_delay) begin
          axi.w_ready = 1'b1;
          seen_w_data = axi.w_data;
          seen_w_strb = axi.w_strb;
        end else begin
          axi.w_ready = 1'b0;
          w_cnt++;
        end
      end else begin
        axi.w_ready = 1'b0;
        w_cnt = 0;
      end
      w_prev      = (axi.w_valid === 1'b1);
      w_prev_data = axi.w_data;
      // B
      if (axi.b_ready === 1'b1) begin
        if (b_cnt >= b_delay) begin
          axi.b_valid = 1'b1; axi.b_resp = wr_resp;
        end else begin
          axi.b_valid = 1'b0; b_cnt++;
        end
      end else begin
        axi.b_valid = 1'b0; b_cnt = 0;
      end
    end
  end

  // ---------------- scoreboard ----------------
  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
    end
  endtask

  task automatic check_rdata(input string tag, input logic [31:0] obs);
    logic [31:0] expv;
    expv = 32'hDEAD_BEEF;
    if (exp_q.size() > 0) expv = exp_q.pop_front();
    check(tag, obs, expv);
  endtask

  // ---------------- driver ----------------
  // Presents one request in IDLE, then waits (bounded) for the rsp pulse.
  // lat counts negedges after the accepting edge up to the one showing rsp.
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [1:0] size,
                        input logic uns, input logic [31:0] wdata,
                        output int lat, output logic [31:0] rdata, output logic err,
                        output logic timeout, output logic extra_pulse);
    @(negedge clock);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_size = size;
    req_unsigned = uns; req_wdata = wdata;
    @(negedge clock);
    req_valid = 1'b0;
    lat = 1;
    while ((rsp_valid !== 1'b1) && (lat < 64)) begin
      @(negedge clock);
      lat++;
    end
    timeout = (rsp_valid !== 1'b1);
    rdata   = rsp_rdata;
    err     = rsp_err;
    @(negedge clock);
    extra_pulse = (rsp_valid === 1'b1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int          lat;
    logic [31:0] rdata;
    logic        err, timeout, extra;
    int          ar_before, aw_before, w_before, wu_before;
    int          exp_stall;

    req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0; req_size = 2'b00;
    req_unsigned = 1'b0; req_wdata = 32'h0;
    reset = 1'b1;
    repeat (3) @(negedge clock);

    // Reset state
    check("rst_ar_valid", 32'(axi.ar_valid), 32'd0);
    check("rst_aw_valid", 32'(axi.aw_valid), 32'd0);
    check("rst_w_valid",  32'(axi.w_valid),  32'd0);
    check("rst_r_ready",  32'(axi.r_ready),  32'd0);
    check("rst_b_ready",  32'(axi.b_ready),  32'd0);
    check("rst_rsp_valid", 32'(rsp_valid),   32'd0);
    check("rst_rsp_rdata", rsp_rdata,        32'd0);
    check("rst_w_data",   axi.w_data,        32'd0);
    check("rst_w_strb",   32'(axi.w_strb),   32'd0);
    check("rst_ar_addr",  axi.ar_addr,       32'd0);
    check("rst_state",    32'(state_dbg),    32'(ST_IDLE));
    reset = 1'b0;
    @(negedge clock);
    check("idle_req_ready", 32'(req_ready), 32'd1);

    // 1) signed byte load from lane 3
    rd_data = 32'h80AA_BBCC; rd_resp = 2'b00;
    exp_q.push_back(32'hFFFF_FF80);
    do_req(1'b0, 32'h8000_0003, SIZE_BYTE, 1'b0, 32'h0, lat, rdata, err, timeout, extra);
    check("ldb_timeout", 32'(timeout), 32'd0);
    check("ldb_latency", 32'(lat), 32'd3);
    check("ldb_ar_size", 32'(seen_ar_size), 32'd0);
    check("ldb_ar_addr", seen_ar_addr, 32'h8000_0003);
    check_rdata("ldb_rdata", rdata);
    check("ldb_err", 32'(err), 32'd0);
    check("ldb_single_pulse", 32'(extra), 32'd0);

    // 2) half store to lane 2, zero-wait slave
    exp_q.push_back(32'h0);
    do_req(1'b1, 32'h8000_0002, SIZE_HALF, 1'b0, 32'h0000_1234, lat, rdata, err, timeout, extra);
    check("sth_timeout", 32'(timeout), 32'd0);
    check("sth_aw_w_together", 32'(aw_w_together), 32'd1);
    check("sth_w_data", seen_w_data, 32'h1234_0000);
    check("sth_w_strb", 32'(seen_w_strb), 32'b1100);
    check("sth_aw_size", 32'(seen_aw_size), 32'd1);
    check("sth_aw_addr", seen_aw_addr, 32'h8000_0002);
    check("sth_latency", 32'(lat), 32'd3);
    check_rdata("sth_rdata", rdata);
    check("sth_err", 32'(err), 32'd0);

    // 3) word store: AW accepted at once, W held off for 4 cycles
    aw_delay = 0; w_delay = 4;
    aw_before = aw_valid_cycles; w_before = w_valid_cycles; wu_before = w_unstable;
    do_req(1'b1, 32'h8000_0010, SIZE_WORD, 1'b0, 32'hCAFE_F00D, lat, rdata, err, timeout, extra);
    w_delay = 0;
    check("stw_timeout", 32'(timeout), 32'd0);
    check("stw_aw_valid_cycles", 32'(aw_valid_cycles - aw_before), 32'd1);
    check("stw_w_valid_cycles", 32'(w_valid_cycles - w_before), 32'd5);
    check("stw_w_stable", 32'(w_unstable - wu_before), 32'd0);
    check("stw_w_data", seen_w_data, 32'hCAFE_F00D);
    check("stw_w_strb", 32'(seen_w_strb), 32'b1111);
    check("stw_latency", 32'(lat), 32'd7);
    check("stw_single_pulse", 32'(extra), 32'd0);

    // 4) misaligned word load: no bus activity, error response
    ar_before = ar_valid_cycles;
    exp_q.push_back(32'h0);
    do_req(1'b0, 32'h8000_0001, SIZE_WORD, 1'b0, 32'h0, lat, rdata, err, timeout, extra);
    check("misw_no_ar", 32'(ar_valid_cycles - ar_before), 32'd0);
    check("misw_latency", 32'(lat), 32'd1);
    check("misw_err", 32'(err), 32'd1);
    check_rdata("misw_rdata", rdata);

    //    size 3 store is always misaligned
    aw_before = aw_valid_cycles;
    do_req(1'b1, 32'h8000_0000, 2'd3, 1'b0, 32'h1111_1111, lat, rdata, err, timeout, extra);
    check("mis3_no_aw", 32'(aw_valid_cycles - aw_before), 32'd0);
    check("mis3_err", 32'(err), 32'd1);

    // 5) load with SLVERR
    rd_data = 32'h1122_3344; rd_resp = 2'b10;
    do_req(1'b0, 32'h8000_0020, SIZE_WORD, 1'b0, 32'h0, lat, rdata, err, timeout, extra);
    rd_resp = 2'b00;
    check("slverr_err", 32'(err), 32'd1);

    // 6) half loads from lane 2, signed and unsigned
    rd_data = 32'h8123_4567;
    exp_q.push_back(32'hFFFF_8123);
    do_req(1'b0, 32'h8000_0102, SIZE_HALF, 1'b0, 32'h0, lat, rdata, err, timeout, extra);
    check_rdata("ldh_signed", rdata);
    exp_q.push_back(32'h0000_8123);
    do_req(1'b0, 32'h8000_0102, SIZE_HALF, 1'b1, 32'h0, lat, rdata, err, timeout, extra);
    check_rdata("ldh_unsigned", rdata);
    //    unsigned byte from lane 1
    rd_data = 32'h0000_F500;
    exp_q.push_back(32'h0000_00F5);
    do_req(1'b0, 32'h8000_0201, SIZE_BYTE, 1'b1, 32'h0, lat, rdata, err, timeout, extra);
    check_rdata("ldbu_lane1", rdata);

    // 7) byte store to lane 1, write response error
    wr_resp = 2'b11;
    do_req(1'b1, 32'h8000_0301, SIZE_BYTE, 1'b0, 32'h0000_00AB, lat, rdata, err, timeout, extra);
    wr_resp = 2'b00;
    check("stb_w_data", seen_w_data, 32'h0000_AB00);
    check("stb_w_strb", 32'(seen_w_strb), 32'b0010);
    check("stb_decerr", 32'(err), 32'd1);

    // 8) reset while waiting in RD_ADDR
    ar_delay = 20;
    @(negedge clock);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h8000_0400;
    req_size = SIZE_WORD; req_unsigned = 1'b0;
    @(negedge clock);
    req_valid = 1'b0;
    check("rst_mid_ar_valid_before", 32'(axi.ar_valid), 32'd1);
    @(negedge clock);
    check("rst_mid_req_ignored", 32'(req_ready), 32'd0);
    reset = 1'b1;
    @(negedge clock);
    check("rst_mid_ar_valid_after", 32'(axi.ar_valid), 32'd0);
    reset = 1'b0;
    ar_delay = 0;
    @(negedge clock);
    check("rst_mid_req_ready", 32'(req_ready), 32'd1);
    check("rst_mid_state", 32'(state_dbg), 32'(ST_IDLE));

`ifdef LSU_AXI_PERF_EN
    // 9) counters: 3 loads + 2 stores, two wait cycles on every channel
    check("perf_load_rst", perf_load_cnt, 32'd0);
    check("perf_stall_rst", perf_stall_cnt, 32'd0);
    ar_delay = 2; r_delay = 2; aw_delay = 2; w_delay = 2; b_delay = 2;
    rd_data = 32'h0000_0001;
    exp_stall = 0;
    for (int i = 0; i < 5; i++) begin
      do_req((i >= 3), 32'h8000_0500 + 32'(i * 4), SIZE_WORD, 1'b0, 32'(i), lat, rdata, err, timeout, extra);
      // two channel phases, each waiting 2 cycles then handshaking
      exp_stall += 2 * (2 + 1);
      check("perf_txn_latency", 32'(lat), 32'd7);
    end
    ar_delay = 0; r_delay = 0; aw_delay = 0; w_delay = 0; b_delay = 0;
    check("perf_load_cnt", perf_load_cnt, 32'd3);
    check("perf_store_cnt", perf_store_cnt, 32'd2);
    check("perf_stall_cnt", perf_stall_cnt, 32'(exp_stall));
`endif

    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute bound on run time
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
